perf_event_counters: RTL and testbench

//  Synthesizable hardware event counters fed by the ROB commit ports and the decode flush/WFI signals.

---
 rtl/perf_pkg.sv | 10 +
 rtl/perf_counter_cell.sv | 17 +
 rtl/perf_event_counters.sv | 74 +++++++
 tb/tb_perf_event_counters.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared counter width, FSM state type and counter indices for the perf event counters
package perf_pkg;
  localparam int PERF_CNT_W = 64;
  typedef enum logic [1:0] {PERF_RUN, PERF_DRAIN, PERF_HALT} perf_state_e;
  localparam logic [1:0] PERF_CYCLE = 2'd0;
  localparam logic [1:0] PERF_INSTRET = 2'd1;
  localparam logic [1:0] PERF_BRANCH = 2'd2;
  localparam logic [1:0] PERF_MISPRED = 2'd3;
  typedef logic [PERF_CNT_W-1:0] perf_cnt_t;
endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: W-bit wrapping counter; adds inc (0..3) when en, zeroes on clr or rst_n low
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst_n || clr) q <= '0;
    else if (en) q <= q + W'(inc);
endmodule

// File: rtl/perf_event_counters.sv
// perf_event_counters: cycle/instret/branch/mispred counters with WFI drain-then-freeze and a 32-bit lo/hi shadowed read port
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_W,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb1_valid_commit,
  input  logic        wb1_flushed,
  input  logic        wb1_is_branch,
  input  logic        wb2_valid_commit,
  input  logic        wb2_flushed,
  input  logic        wb2_is_branch,
  input  logic        must_flush,
  input  logic        wfi_a,
  input  logic        wfi_b,
  input  logic        clr,
  input  logic        rd_req,
  input  logic [2:0]  rd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        halted
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  perf_state_e state;
  logic [DW-1:0] drain;
  logic [CNT_W-1:0] cnt [4];
  logic [31:0] shadow;
  logic [63:0] sel;
  logic ret1, ret2, br1, br2, run;
  assign ret1 = wb1_valid_commit & ~wb1_flushed;
  assign ret2 = wb2_valid_commit & ~wb2_flushed;
  assign br1 = ret1 & wb1_is_branch;
  assign br2 = ret2 & wb2_is_branch;
  assign run = state != PERF_HALT;
  assign halted = state == PERF_HALT;
  assign sel = 64'(cnt[rd_addr[2:1]]);
  perf_counter_cell #(.W(CNT_W)) u_cycle (.clk(clk), .rst_n(rst_n), .en(run), .clr(clr), .inc(2'd1), .q(cnt[PERF_CYCLE]));
  perf_counter_cell #(.W(CNT_W)) u_instret (.clk(clk), .rst_n(rst_n), .en(run), .clr(clr), .inc({1'b0, ret1} + {1'b0, ret2}), .q(cnt[PERF_INSTRET]));
  perf_counter_cell #(.W(CNT_W)) u_branch (.clk(clk), .rst_n(rst_n), .en(run), .clr(clr), .inc({1'b0, br1} + {1'b0, br2}), .q(cnt[PERF_BRANCH]));
  perf_counter_cell #(.W(CNT_W)) u_mispred (.clk(clk), .rst_n(rst_n), .en(run), .clr(clr), .inc({1'b0, must_flush}), .q(cnt[PERF_MISPRED]));
  // The WFI cycle is the first of DRAIN_CYCLES counted cycles, so DRAIN leaves when the
  // counter is about to hit zero; a single drain cycle means halting straight from RUN.
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      state <= PERF_RUN;
      drain <= '0;
    end else
      case (state)
        PERF_RUN:
          if (wfi_a | wfi_b) begin
            state <= DRAIN_CYCLES == 1 ? PERF_HALT : PERF_DRAIN;
            drain <= DW'(DRAIN_CYCLES - 1);
          end
        PERF_DRAIN: begin
          drain <= drain - 1'b1;
          state <= drain == DW'(1) ? PERF_HALT : PERF_DRAIN;
        end
        default: ;
      endcase
  // Odd addresses are hi halves and return the shadow captured by the preceding lo read.
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      shadow <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_addr[0] ? shadow : sel[31:0];
      if (rd_req && !rd_addr[0]) shadow <= sel[63:32];
    end
endmodule

// File: tb/tb_perf_event_counters.sv
// tb_perf_event_counters: directed self-checking bench for perf_event_counters
module tb_perf_event_counters;
  logic clk = 1'b0;
  logic rst_n, wb1_valid_commit, wb1_flushed, wb1_is_branch;
  logic wb2_valid_commit, wb2_flushed, wb2_is_branch;
  logic must_flush, wfi_a, wfi_b, clr, rd_req;
  logic [2:0] rd_addr;
  logic rd_valid, halted;
  logic [31:0] rd_data;
  int total = 0;
  int bad = 0;
  perf_event_counters #(.CNT_W(64), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb1_valid_commit(wb1_valid_commit), .wb1_flushed(wb1_flushed), .wb1_is_branch(wb1_is_branch),
    .wb2_valid_commit(wb2_valid_commit), .wb2_flushed(wb2_flushed), .wb2_is_branch(wb2_is_branch),
    .must_flush(must_flush), .wfi_a(wfi_a), .wfi_b(wfi_b), .clr(clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    rd_req = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, 64'(rd_data), 64'(exp));
  endtask
  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    {wb1_valid_commit, wb1_flushed, wb1_is_branch, wb2_valid_commit, wb2_flushed, wb2_is_branch} = '0;
    {must_flush, wfi_a, wfi_b, clr, rd_req} = '0;
    rd_addr = '0;
    rst_n = 1'b0;
    idle(3);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    rst_n = 1'b1;
    idle(10);
    rd_chk("idle_cycle_lo", 3'd0, 32'd10);
    rd_chk("idle_cycle_hi", 3'd1, 32'd0);
    rd_chk("idle_instret", 3'd2, 32'd0);
    rd_chk("idle_branch", 3'd4, 32'd0);
    rd_chk("idle_mispred", 3'd6, 32'd0);
    check("idle_halted", 64'(halted), 64'd0);
    clear();
    wb1_valid_commit = 1'b1;
    wb2_valid_commit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb2_flushed = i < 3;
      @(negedge clk);
    end
    {wb1_valid_commit, wb2_valid_commit, wb2_flushed} = '0;
    rd_chk("instret_lo", 3'd2, 32'd13);
    rd_chk("instret_hi", 3'd3, 32'd0);
    rd_chk("instret_branch", 3'd4, 32'd0);
    clear();
    {wb1_valid_commit, wb1_is_branch, wb2_valid_commit, wb2_is_branch} = 4'hf;
    @(negedge clk);
    {wb2_valid_commit, wb2_is_branch} = 2'b00;
    wb1_flushed = 1'b1;
    @(negedge clk);
    {wb1_valid_commit, wb1_is_branch, wb1_flushed} = 3'b000;
    must_flush = 1'b1;
    idle(5);
    must_flush = 1'b0;
    rd_chk("branch_lo", 3'd4, 32'd2);
    rd_chk("branch_instret", 3'd2, 32'd2);
    rd_chk("mispred_lo", 3'd6, 32'd5);
    clear();
    wfi_a = 1'b1;
    @(negedge clk);
    wfi_a = 1'b0;
    check("drain_halted_1", 64'(halted), 64'd0);
    wfi_b = 1'b1;
    @(negedge clk);
    wfi_b = 1'b0;
    check("drain_halted_2", 64'(halted), 64'd0);
    @(negedge clk);
    check("drain_halted_3", 64'(halted), 64'd0);
    @(negedge clk);
    check("drain_halted_4", 64'(halted), 64'd1);
    rd_chk("halt_cycle_a", 3'd0, 32'd4);
    idle(20);
    rd_chk("halt_cycle_b", 3'd0, 32'd4);
    wb1_valid_commit = 1'b1;
    must_flush = 1'b1;
    @(negedge clk);
    {wb1_valid_commit, must_flush} = 2'b00;
    rd_chk("halt_instret", 3'd2, 32'd0);
    rd_chk("halt_mispred", 3'd6, 32'd0);
    clear();
    check("clr_halted", 64'(halted), 64'd0);
    rd_req = 1'b1;
    rd_addr = 3'd0;
    @(negedge clk);
    check("b2b_valid_a", 64'(rd_valid), 64'd1);
    check("b2b_data_a", 64'(rd_data), 64'd0);
    @(negedge clk);
    rd_req = 1'b0;
    check("b2b_valid_b", 64'(rd_valid), 64'd1);
    check("b2b_data_b", 64'(rd_data), 64'd1);
    @(negedge clk);
    check("b2b_valid_off", 64'(rd_valid), 64'd0);
    force dut.u_cycle.q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.u_cycle.q;
    @(negedge clk);
    rd_chk("atomic_lo_a", 3'd0, 32'hFFFF_FFFF);
    rd_chk("atomic_hi_a", 3'd1, 32'h0);
    rd_chk("atomic_lo_b", 3'd0, 32'h1);
    rd_chk("atomic_hi_b", 3'd1, 32'h1);
    clear();
    rd_chk("stale_shadow", 3'd1, 32'h1);
    force dut.u_cycle.q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.u_cycle.q;
    @(negedge clk);
    rd_chk("wrap_lo_a", 3'd0, 32'hFFFF_FFFF);
    rd_chk("wrap_hi_a", 3'd1, 32'hFFFF_FFFF);
    rd_chk("wrap_lo_b", 3'd0, 32'h1);
    rd_chk("wrap_hi_b", 3'd1, 32'h0);
    clear();
    {wb1_valid_commit, wb2_valid_commit, must_flush} = 3'b111;
    idle(3);
    clr = 1'b1;
    rd_req = 1'b1;
    rd_addr = 3'd2;
    @(negedge clk);
    {clr, rd_req, wb1_valid_commit, wb2_valid_commit, must_flush} = '0;
    check("clr_read_preclear", 64'(rd_data), 64'd6);
    rd_chk("clr_cycle", 3'd0, 32'd0);
    rd_chk("clr_instret", 3'd2, 32'd0);
    rd_chk("clr_mispred", 3'd6, 32'd0);
    rd_chk("clr_branch", 3'd4, 32'd0);
    wfi_a = 1'b1;
    @(negedge clk);
    wfi_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_drain_halted", 64'(halted), 64'd0);
    rd_chk("rst_drain_cycle", 3'd0, 32'd0);
    idle(6);
    check("rst_drain_run", 64'(halted), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
